dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder for the pipelined core's memory stage, replacing the zero-wait data memory.
- Accepts one load/store request at a time over a valid/ready handshake, models configurable wait states and returns a one-cycle response.
- Raises `stall` so the hazard logic can freeze earlier stages while an access is outstanding.

Parameters:
- `ADDR_W`, 8: word-index width; array depth is 2**ADDR_W words.
- `DATA_W`, 32: data word width.
- `RD_LAT`, 2: cycles from read accept to response; legal range 1..15.
- `WR_LAT`, 1: cycles from write accept to response and commit; legal range 1..15.

Ports:
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous and active-low.
- `req_valid`  input  1  request present.
- `req_ready`  output  1  responder can accept a request this cycle.
- `req_we`  input  1  1 = store, 0 = load.
- `req_addr`  input  32  byte address; word index = `req_addr[ADDR_W+1:2]`.
- `req_wdata`  input  `DATA_W`  store data.
- `rsp_valid`  output  1  one-cycle response pulse.
- `rsp_rdata`  output  `DATA_W`  load data; 0 for stores and errors.
- `rsp_err`  output  1  access rejected; valid only with `rsp_valid`.
- `stall`  output  1  access outstanding; pipeline must hold.

Behaviour:
- Reset (`rst` = 0, asynchronous):
  - State = IDLE; `rsp_valid`, `rsp_err` = 0; `rsp_rdata` = 0; counter = 0.
  - Whole array cleared to 0.
  - `req_ready` = 1 as soon as reset is released.
- States and transitions:
  - IDLE: `req_ready` = 1. On `req_valid` at an edge: latch `we`/`addr`/`wdata`, load counter with L-1 (L = `RD_LAT` or `WR_LAT`), go to BUSY.
  - BUSY: `req_ready` = 0, `stall` = 1. Decrement the counter each edge. At the edge where the counter is 0, perform the access, register the response and go to RESP.
  - RESP: `rsp_valid` = 1 for exactly this cycle and `req_ready` = 1. A new request with `req_valid` high is accepted at the next edge (back-to-back, go to BUSY); otherwise go to IDLE.
- Latency:
  - Accept at edge k; `rsp_valid` is high in the cycle after edge k+L.
  - Back-to-back throughput is one access per L+1 cycles.
- Stall: `stall` = (state == BUSY), combinational from state only; it does not depend on `req_valid`.
- Store:
  - Array word written at the response edge, not at accept.
  - `rsp_rdata` = 0.
- Load: `rsp_rdata` = array word sampled at the response edge, so it reflects a store committed at an earlier response edge.
- Out of range:
  - Condition: `req_addr[31:ADDR_W+2]` is nonzero.
  - No write; `rsp_rdata` = 0; `rsp_err` = 1; latency unchanged.
- Request inputs are ignored while `req_ready` = 0.
- A parameter value of 0 is treated as 1.
- Reset mid-access: the pending access is dropped, no write is committed, and no response is issued.

Optional Feature:
- `DMEM_ALIGN_CHECK_EN` defined:
  - `req_addr[1:0]` != 0 gives `rsp_err` = 1, with no write and `rsp_rdata` = 0.
  - Normal latency.
- `DMEM_ALIGN_CHECK_EN` undefined: `req_addr[1:0]` ignored; misaligned accesses hit the containing word.

Decomposition:
- Shared package `dmem_pkg`:
  - State enum {IDLE, BUSY, RESP}.
  - Default latency constants.
  - Counter width constant (4).
- One sub-module `dmem_storage`:
  - Synchronous-write, clocked-read word array.
  - Async active-low clear; single read/write port.
  - The FSM and counter stay in `dmem_responder`.

Test Plan:
- Reset release: `rsp_valid` = 0, `rsp_rdata` = 0, `stall` = 0, `req_ready` = 1. A load from address 0x0 returns 0x00000000 after 2 cycles.
- Store 0xDEADBEEF to 0x10 (`WR_LAT` = 1), then load 0x10:
  - Store `rsp_valid` one cycle after accept edge+1; `stall` high 1 cycle.
  - Load returns 0xDEADBEEF with `rsp_err` = 0, `stall` high 2 cycles.
- Out of range: load 0x400 (`ADDR_W` = 8) gives `rsp_err` = 1, `rsp_rdata` = 0. Store 0x400 leaves word 0 unchanged on readback.
- Back-to-back: `req_valid` held high with loads of 0x4, 0x8 gives responses exactly 3 cycles apart, and the second accept occurs in the RESP cycle of the first.
- Reset mid-access: store 0x55 to 0x20, assert `rst` while BUSY. After release, a load of 0x20 returns 0, with no spurious `rsp_valid` during or after reset.
- With `DMEM_ALIGN_CHECK_EN`: store to 0x22 gives `rsp_err` = 1 and word 0x20 unchanged. Without the macro: the same store writes word 0x20.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, default
// latencies and the wait-state counter width.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int unsigned DMEM_RD_LAT_DEF = 32'd2;
    localparam int unsigned DMEM_WR_LAT_DEF = 32'd1;
    localparam int unsigned DMEM_CNT_W      = 32'd4;

    // Convert a latency in cycles into the counter preload value (L-1).
    // A latency of 0 behaves like 1; values above 15 saturate at 15.
    function automatic logic [DMEM_CNT_W-1:0] lat_to_cnt(input int unsigned lat);
        logic [DMEM_CNT_W-1:0] cnt;
        if (lat <= 32'd1) begin
            cnt = '0;
        end else if (lat >= 32'd15) begin
            cnt = DMEM_CNT_W'(14);
        end else begin
            cnt = DMEM_CNT_W'(lat - 32'd1);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/dmem_storage.sv
// Word array behind the responder: one shared read/write port, synchronous
// write, registered read data that returns to zero when no read is issued,
// and an asynchronous active-low clear of every word.
module dmem_storage
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32'd8,
    parameter int unsigned DATA_W = 32'd32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Array contents: cleared on reset, written on a committed store.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register: captures the addressed word on a read, zero otherwise,
    // so stores and rejected accesses naturally respond with zero data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the memory stage. Accepts one load/store at a
// time, waits RD_LAT/WR_LAT cycles, then returns a one-cycle response.
// stall is high while an access is outstanding.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject accesses whose byte
// address is not word aligned (rsp_err = 1, no write, zero data).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32'd8,
    parameter int unsigned DATA_W = 32'd32,
    parameter int unsigned RD_LAT = DMEM_RD_LAT_DEF,
    parameter int unsigned WR_LAT = DMEM_WR_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              stall
);

    localparam logic [DMEM_CNT_W-1:0] RD_CNT = lat_to_cnt(RD_LAT);
    localparam logic [DMEM_CNT_W-1:0] WR_CNT = lat_to_cnt(WR_LAT);
    localparam int unsigned           IDX_LO = 32'd2;
    localparam int unsigned           IDX_HI = ADDR_W + 32'd2;

    dmem_state_e           state_q, state_d;
    logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  req_err_s;
    logic                  mem_we_s;
    logic                  mem_re_s;
    logic [DATA_W-1:0]     mem_rdata_s;

    // Decide at accept time whether the request will be rejected; the verdict
    // travels with the request so latency is the same as a good access.
`ifdef DMEM_ALIGN_CHECK_EN
    always_comb begin
        req_err_s = ((req_addr >> IDX_HI) != 32'd0) || (req_addr[1:0] != 2'b00);
    end
`else
    logic unused_align_s;
    assign unused_align_s = ^req_addr[1:0];

    always_comb begin
        req_err_s = ((req_addr >> IDX_HI) != 32'd0);
    end
`endif

    // Next-state logic: accept in IDLE or RESP, count wait states in BUSY,
    // perform the access and raise the response when the count expires.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        err_d       = err_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        mem_we_s    = 1'b0;
        mem_re_s    = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (req_valid) begin
                    we_d    = req_we;
                    err_d   = req_err_s;
                    idx_d   = req_addr[IDX_HI-1:IDX_LO];
                    wdata_d = req_wdata;
                    cnt_d   = req_we ? WR_CNT : RD_CNT;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    mem_we_s    = we_q & ~err_q;
                    mem_re_s    = ~we_q & ~err_q;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - DMEM_CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, request latch and response flags; reset drops any pending access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    dmem_storage #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_storage (
        .clk_i   (clk),
        .rst_ni  (rst),
        .we_i    (mem_we_s),
        .re_i    (mem_re_s),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata_s)
    );

    assign req_ready = (state_q != BUSY);
    assign stall     = (state_q == BUSY);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = mem_rdata_s;

endmodule
